// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register pending-write scoreboard gating IF/ID issue; ID_SB_WB_BYPASS_EN forwards same-cycle writebacks
module id_scoreboard #(
  parameter int NUM_SRC = 3,
  parameter int NUM_WB  = 3,
  parameter int CNT_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*NUM_SRC-1:0] src_group,
  input  logic [5*NUM_SRC-1:0] src_index,
  input  logic [1:0]           dst_group,
  input  logic [4:0]           dst_index,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic [NUM_WB-1:0]    wb_valid,
  input  logic [2*NUM_WB-1:0]  wb_group,
  input  logic [5*NUM_WB-1:0]  wb_index,
  input  logic                 flush,
  output logic                 conflict,
  output logic                 pending_any
);
  localparam logic [1:0] G_INV = 2'd0;
  localparam logic [1:0] G_R   = 2'd1;
  localparam int EW = CNT_W + 3;
  logic [CNT_W-1:0] cnt     [0:95];
  logic [CNT_W-1:0] cnt_nxt [0:95];
  logic [EW-1:0]    dec     [0:95];
  logic [NUM_SRC-1:0] src_hit;
  logic dst_trk, dst_sat, issue, any_nxt;
  logic [6:0] dst_idx;

  function automatic logic trk(input logic [1:0] g, input logic [4:0] i);
    return g != G_INV && !(g == G_R && i == 5'd0);
  endfunction

  function automatic logic [6:0] idx(input logic [1:0] g, input logic [4:0] i);
    logic [1:0] b;
    b = g - 2'd1;
    return {b, i};
  endfunction

  // count of writeback ports retiring each register this cycle
  always_comb begin
    for (int r = 0; r < 96; r++) begin
      dec[r] = '0;
      for (int w = 0; w < NUM_WB; w++)
        if (wb_valid[w] && trk(wb_group[2*w +: 2], wb_index[5*w +: 5]) &&
            idx(wb_group[2*w +: 2], wb_index[5*w +: 5]) == 7'(r))
          dec[r] = dec[r] + EW'(1);
    end
  end

  // RAW hazard per source on current counters; bypass build forgives a register fully retiring now
  always_comb begin
    src_hit = '0;
    for (int k = 0; k < NUM_SRC; k++)
      src_hit[k] = trk(src_group[2*k +: 2], src_index[5*k +: 5]) &&
                   cnt[idx(src_group[2*k +: 2], src_index[5*k +: 5])] != '0
`ifdef ID_SB_WB_BYPASS_EN
                   && EW'(cnt[idx(src_group[2*k +: 2], src_index[5*k +: 5])]) !=
                      dec[idx(src_group[2*k +: 2], src_index[5*k +: 5])]
`endif
                   ;
  end

  assign dst_trk  = trk(dst_group, dst_index);
  assign dst_idx  = idx(dst_group, dst_index);
  assign dst_sat  = dst_trk && cnt[dst_idx] == '1;
  assign conflict = in_valid & (|src_hit | dst_sat);
  assign in_ready = (out_ready | ~out_valid) & ~conflict & ~flush;
  assign issue    = in_valid & in_ready;

  // next counters: issue increment minus writeback decrements, floored at zero
  always_comb begin
    any_nxt = 1'b0;
    for (int r = 0; r < 96; r++) begin
      cnt_nxt[r] = (EW'(cnt[r]) + EW'(issue && dst_trk && dst_idx == 7'(r))) > dec[r] ?
                   CNT_W'(EW'(cnt[r]) + EW'(issue && dst_trk && dst_idx == 7'(r)) - dec[r]) : '0;
      any_nxt = any_nxt | (cnt_nxt[r] != '0);
    end
  end

  // counter bank, EX-side valid and registered pending flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < 96; r++) cnt[r] <= '0;
      out_valid   <= 1'b0;
      pending_any <= 1'b0;
    end else begin
      for (int r = 0; r < 96; r++) cnt[r] <= cnt_nxt[r];
      out_valid   <= flush ? 1'b0 : in_ready ? in_valid : out_ready ? 1'b0 : out_valid;
      pending_any <= any_nxt;
    end
  end
endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 Parameter NUM_SRC, default 3, number of source operands checked per instruction (1..4).
REQ-002 Parameter NUM_WB, default 3, number of writeback clear ports (1..4).
REQ-003 Parameter CNT_W, default 2, width of each per-register pending-write counter (1..4).
REQ-004 Ports SHALL be:
clk  in  1  sole clock, all state updates on rising edge.
rst  in  1  synchronous reset, active-low (state reset on rising clk while rst==0).
in_valid  in  1  decoded instruction presented by IF/ID.
in_ready  out  1  scoreboard accepts instruction this cycle.
src_group  in  2*NUM_SRC  per-source register group, REG_GROUP_* encoding.
src_index  in  5*NUM_SRC  per-source register index.
dst_group  in  2  destination group, REG_GROUP_* encoding.
dst_index  in  5  destination index.
out_valid  out  1  registered instruction valid toward EX.
out_ready  in  1  EX accepts.
wb_valid  in  NUM_WB  writeback port retiring a destination.
wb_group  in  2*NUM_WB  writeback group.
wb_index  in  5*NUM_WB  writeback index.
flush  in  1  discard the instruction held toward EX.
conflict  out  1  instruction blocked by RAW hazard or counter saturation.
pending_any  out  1  at least one pending counter nonzero.

Function
REQ-005 State: one CNT_W-bit counter per (group, index) for groups R, F, M (96 counters); REG_GROUP_INVALID and R index 0 SHALL never be tracked, read as zero, never block.
REQ-006 src_hit[k] = src_group[k] tracked and counter(src_group[k], src_index[k]) != 0, evaluated combinationally on current counter values.
REQ-007 dst_sat = dst tracked and counter(dst) == 2^CNT_W-1.
REQ-008 conflict = in_valid & (OR of src_hit | dst_sat); combinational, no latency.
REQ-009 in_ready = (out_ready | !out_valid) & !conflict & !flush.
REQ-010 Issue = in_valid & in_ready; on issue counter(dst) SHALL increment by one next edge (if tracked).
REQ-011 Each asserted wb port with tracked target SHALL decrement that counter by one next edge; k ports on same register decrement by k.
REQ-012 Net update per counter = increments - decrements in same cycle; increment and single decrement same register SHALL leave value unchanged.
REQ-013 Decrement below zero SHALL saturate at zero (no wrap); increment never wraps because dst_sat blocks issue.
REQ-014 out_valid next: flush -> 0; else in_ready -> in_valid; else out_ready -> 0; else hold.
REQ-015 flush SHALL not modify counters; instructions already issued retire through wb ports.
REQ-016 pending_any SHALL be registered OR of all counters, reflecting post-update state one cycle after change.

Reset
REQ-017 While rst==0 at clk edge: all counters 0, out_valid 0, pending_any 0; wb and in ports ignored that cycle.
REQ-018 Reset mid-operation SHALL discard all pending state; in-flight writebacks arriving after reset saturate at zero per REQ-013.
REQ-019 in_ready, conflict combinational; with counters zero after reset, conflict = 0.

Configuration
REQ-020 Macro ID_SB_WB_BYPASS_EN defined: src_hit SHALL exclude a register whose counter equals the number of same-cycle wb hits on it (writeback forwarded, zero-stall RAW).
REQ-021 ID_SB_WB_BYPASS_EN undefined: src_hit uses counter value only; RAW resolves one cycle after the final writeback.
REQ-022 Counter update logic SHALL be identical in both builds.

Verification
REQ-023 Reset then in_valid, dst=R x5, srcs invalid, out_ready=1 -> in_ready=1, next cycle out_valid=1, counter(R5)=1, pending_any=1.
REQ-024 Counter(R5)=1, instruction src R5 -> conflict=1, in_ready=0; wb R5 same cycle -> bypass build in_ready=1, non-bypass build in_ready=0 then 1 next cycle.
REQ-025 Source R x0 and dst R x0 repeatedly issued -> conflict never 1, pending_any stays 0.
REQ-026 CNT_W=2, three issues to M3 without wb -> counter 3, fourth dst=M3 -> conflict=1 until one wb M3.
REQ-027 Counter(F7)=1, issue dst F7 and wb F7 same cycle -> counter stays 1; two wb ports both F7 with counter 1 -> counter 0, no underflow.
REQ-028 out_valid=1, out_ready=0, flush=1 -> next cycle out_valid=0, counters unchanged; rst=0 with counters nonzero -> all zero next cycle.
